// File: rtl/irq_pkg.sv
// Shared constants and the priority encoder used by the interrupt front end.
package irq_pkg;

    localparam int N_IRQ_DEF       = 3;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_IRQ         = 8;
    localparam int IDX_W           = $clog2(MAX_IRQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } hi_t;

    // Highest set bit of vec; valid = 0 when vec is all zero.
    function automatic hi_t hi_index(input logic [MAX_IRQ-1:0] vec);
        hi_t res;
        res = '0;
        for (int i = 0; i < MAX_IRQ; i++) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-stage synchroniser plus previous-value flop; flags rising edges per line.
module irq_sync_edge #(
    parameter int N      = 3,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] rise
);

    logic [STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]             prev_q;

    // NOTE: synchroniser stages are reset like any control flop (unlike RAM storage)
    // so a line already high at release is seen as exactly one clean edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: edge-latched pending events, masking, fixed priority and
// an in-service nest stack so only strictly higher-priority sources preempt.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ID_W        = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             irq_ack,
    input  logic             irq_eret,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack_vec, eret_vec, above, eligible;
    logic [N_IRQ-1:0] pending_nxt, in_service_nxt;
    hi_t              top_is, top_nxt, req_hi;
    logic             req_nxt;
    logic [ID_W-1:0]  id_nxt;

    irq_sync_edge #(
        .N      (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (irq_in),
        .rise (rise)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        ack_vec  = '0;
        eret_vec = '0;
        above    = '1;
        top_is   = hi_index(MAX_IRQ'(in_service));

        if (irq_ack && irq_req)
            ack_vec = N_IRQ'(1) << irq_id;
        if (irq_eret && top_is.valid)
            eret_vec = N_IRQ'(1) << top_is.idx;

        // Set beats ack on the same source; eret clears the old top before the ack sets.
        pending_nxt    = (pending & ~ack_vec) | rise;
        in_service_nxt = (in_service & ~eret_vec) | ack_vec;

        // Only sources strictly above the top in-service index may request.
        top_nxt = hi_index(MAX_IRQ'(in_service_nxt));
        if (top_nxt.valid)
            above = ~((N_IRQ'(2) << top_nxt.idx) - N_IRQ'(1));

        eligible = pending_nxt & irq_mask & above;
        req_hi   = hi_index(MAX_IRQ'(eligible));
        req_nxt  = req_hi.valid;
        id_nxt   = req_hi.valid ? ID_W'(req_hi.idx) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            in_service <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
        end else begin
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            irq_req    <= req_nxt;
            irq_id     <= id_nxt;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with N_IRQ = 3 and SYNC_STAGES = 2.
module tb_irq_controller;

    localparam int N   = 3;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   irq_in = '0;
    logic [N-1:0]   irq_mask = '0;
    logic           irq_ack = 1'b0;
    logic           irq_eret = 1'b0;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   in_service;

    int n_checks = 0;
    int n_pass   = 0;

    irq_controller #(.N_IRQ(N), .SYNC_STAGES(2), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .irq_ack    (irq_ack),
        .irq_eret   (irq_eret),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_state(input string tag, input logic req, input logic [IDW-1:0] id,
                                input logic [N-1:0] pend, input logic [N-1:0] isv);
        check({tag, ".req"}, 32'(irq_req), 32'(req));
        check({tag, ".id"}, 32'(irq_id), 32'(id));
        check({tag, ".pending"}, 32'(pending), 32'(pend));
        check({tag, ".in_service"}, 32'(in_service), 32'(isv));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Two-cycle pulse; returns right after the edge that latches it into pending.
    task automatic pulse(input logic [N-1:0] lines);
        irq_in = irq_in | lines;
        tick(2);
        irq_in = irq_in & ~lines;
        tick(1);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic do_eret();
        irq_eret = 1'b1;
        tick(1);
        irq_eret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        expect_state("reset", 1'b0, 2'd0, 3'b000, 3'b000);
        rst = 1'b1;
        tick(1);

        // Single event with exact edge-to-request latency.
        irq_mask  = 3'b111;
        irq_in[1] = 1'b1;
        tick(2);
        check("single.latency_req", 32'(irq_req), 32'd0);
        irq_in[1] = 1'b0;
        tick(1);
        expect_state("single.req", 1'b1, 2'd1, 3'b010, 3'b000);
        do_ack();
        expect_state("single.ack", 1'b0, 2'd0, 3'b000, 3'b010);
        do_eret();
        expect_state("single.eret", 1'b0, 2'd0, 3'b000, 3'b000);

        // Priority and nesting.
        pulse(3'b101);
        expect_state("prio.req", 1'b1, 2'd2, 3'b101, 3'b000);
        do_ack();
        expect_state("prio.ack", 1'b0, 2'd0, 3'b001, 3'b100);
        do_eret();
        expect_state("prio.eret", 1'b1, 2'd0, 3'b001, 3'b000);

        // Preemption of source 0 by source 1.
        do_ack();
        expect_state("preempt.ack0", 1'b0, 2'd0, 3'b000, 3'b001);
        pulse(3'b010);
        expect_state("preempt.req1", 1'b1, 2'd1, 3'b010, 3'b001);
        do_ack();
        expect_state("preempt.ack1", 1'b0, 2'd0, 3'b000, 3'b011);
        do_eret();
        expect_state("preempt.eret1", 1'b0, 2'd0, 3'b000, 3'b001);
        do_eret();
        expect_state("preempt.eret2", 1'b0, 2'd0, 3'b000, 3'b000);

        // Mask gates the request only.
        irq_mask = 3'b011;
        pulse(3'b100);
        expect_state("mask.masked", 1'b0, 2'd0, 3'b100, 3'b000);
        irq_mask = 3'b111;
        tick(1);
        expect_state("mask.unmask", 1'b1, 2'd2, 3'b100, 3'b000);
        do_ack();
        do_eret();
        expect_state("mask.clean", 1'b0, 2'd0, 3'b000, 3'b000);

        // Ack and new edge on the same source: set wins.
        pulse(3'b010);
        expect_state("ackedge.req", 1'b1, 2'd1, 3'b010, 3'b000);
        irq_in[1] = 1'b1;
        tick(2);
        do_ack();
        irq_in[1] = 1'b0;
        expect_state("ackedge.after", 1'b0, 2'd0, 3'b010, 3'b010);

        // Ack together with eret.
        pulse(3'b100);
        expect_state("ackeret.req", 1'b1, 2'd2, 3'b110, 3'b010);
        irq_ack  = 1'b1;
        irq_eret = 1'b1;
        tick(1);
        irq_ack  = 1'b0;
        irq_eret = 1'b0;
        expect_state("ackeret.both", 1'b0, 2'd0, 3'b010, 3'b100);
        do_eret();
        expect_state("ackeret.eret", 1'b1, 2'd1, 3'b010, 3'b000);
        do_ack();
        expect_state("ackeret.ack1", 1'b0, 2'd0, 3'b000, 3'b010);
        do_eret();
        expect_state("ackeret.clean", 1'b0, 2'd0, 3'b000, 3'b000);

        // Eret with nothing in service, and ack with no request, are ignored.
        do_eret();
        expect_state("idle.eret", 1'b0, 2'd0, 3'b000, 3'b000);
        do_ack();
        expect_state("idle.ack", 1'b0, 2'd0, 3'b000, 3'b000);

        // Reset mid-service with irq_in[0] held high.
        pulse(3'b001);
        do_ack();
        pulse(3'b010);
        expect_state("rst.pre_req", 1'b1, 2'd1, 3'b010, 3'b001);
        irq_in[0] = 1'b1;
        tick(3);
        expect_state("rst.pre_pend", 1'b1, 2'd1, 3'b011, 3'b001);
        #3 rst = 1'b0;
        #1 expect_state("rst.async", 1'b0, 2'd0, 3'b000, 3'b000);
        tick(2);
        rst = 1'b1;
        tick(2);
        check("rst.latency_req", 32'(irq_req), 32'd0);
        tick(1);
        expect_state("rst.one_event", 1'b1, 2'd0, 3'b001, 3'b000);
        do_ack();
        expect_state("rst.ack", 1'b0, 2'd0, 3'b000, 3'b001);
        tick(5);
        expect_state("rst.no_repeat", 1'b0, 2'd0, 3'b000, 3'b001);
        irq_in = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
